// File: rtl/game_pkg.sv
// Shared types for the game sequencer: FSM state encoding, the keycodes it
// reacts to, and the one-hot key press bundle produced by key_edge_detect.
package game_pkg;

   typedef enum logic [2:0] {
      ST_TITLE      = 3'd0,
      ST_TRANSITION = 3'd1,
      ST_PLAY       = 3'd2,
      ST_PAUSE      = 3'd3,
      ST_OVER       = 3'd4
   } game_state_e;

   localparam logic [7:0] KEY_ONE   = 8'h1E;
   localparam logic [7:0] KEY_TWO   = 8'h1F;
   localparam logic [7:0] KEY_ENTER = 8'h28;
   localparam logic [7:0] KEY_ESC   = 8'h29;
   localparam logic [7:0] KEY_P     = 8'h13;

   // One bit per key; each bit is a single-cycle press event.
   typedef struct packed {
      logic p;
      logic esc;
      logic enter;
      logic two;
      logic one;
   } key_press_t;

endpackage

// File: rtl/key_edge_detect.sv
// Turns the held USB HID keycode into single-cycle press events: a key fires
// once when it appears and again only after it is released and re-pressed.
module key_edge_detect
   import game_pkg::*;
(
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic [7:0] keycode_i,
   output key_press_t press_o
);

   logic [7:0] prev_keycode_q;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         prev_keycode_q <= 8'h00;
      end else begin
         prev_keycode_q <= keycode_i;
      end
   end

   always_comb begin
      press_o       = '0;
      press_o.one   = (keycode_i == KEY_ONE)   && (prev_keycode_q != KEY_ONE);
      press_o.two   = (keycode_i == KEY_TWO)   && (prev_keycode_q != KEY_TWO);
      press_o.enter = (keycode_i == KEY_ENTER) && (prev_keycode_q != KEY_ENTER);
      press_o.esc   = (keycode_i == KEY_ESC)   && (prev_keycode_q != KEY_ESC);
      press_o.p     = (keycode_i == KEY_P)     && (prev_keycode_q != KEY_P);
   end

endmodule

// File: rtl/game_state_ctrl.sv
// Top-level game sequencer: title -> transition -> play -> pause/over flow,
// round timer and player-count latch. Optional GAME_STATE_XSIT_TIMEOUT_EN
// forces TRANSITION -> PLAY after XSIT_TIMEOUT frames without TransitionDone.
module game_state_ctrl
   import game_pkg::*;
#(
   parameter int unsigned ROUND_FRAMES = 3600,
   parameter int unsigned OVER_FRAMES  = 300
`ifdef GAME_STATE_XSIT_TIMEOUT_EN
   ,
   parameter int unsigned XSIT_TIMEOUT = 240
`endif
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        FrameTick,
   input  logic [7:0]  keycode,
   input  logic        TransitionDone,
   output logic        StartGame,
   output logic        StartTransition,
   output logic        GameActive,
   output logic        GameOver,
   output logic        TwoPlayer,
   output logic [15:0] FramesLeft,
   output logic [2:0]  DbgState
);

   localparam logic [15:0] ROUND_LEN = 16'(ROUND_FRAMES);
   localparam logic [15:0] OVER_LAST = 16'(OVER_FRAMES - 1);

   key_press_t  press;
   game_state_e state_q, state_d;
   logic        two_player_q, two_player_d;
   logic [15:0] frames_left_q, frames_left_d;
   logic [15:0] over_cnt_q, over_cnt_d;
   logic        start_game_q, start_xsit_q, game_active_q, game_over_q;

   key_edge_detect u_keys (
      .clk_i     (Clk),
      .reset_i   (Reset),
      .keycode_i (keycode),
      .press_o   (press)
   );

`ifdef GAME_STATE_XSIT_TIMEOUT_EN
   localparam logic [15:0] XSIT_LAST = 16'(XSIT_TIMEOUT - 1);
   logic [15:0] xsit_cnt_q, xsit_cnt_d;
   logic        xsit_expire;

   assign xsit_expire = FrameTick && (xsit_cnt_q == XSIT_LAST);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         xsit_cnt_q <= 16'd0;
      end else begin
         xsit_cnt_q <= xsit_cnt_d;
      end
   end
`endif

   always_comb begin
      state_d       = state_q;
      two_player_d  = two_player_q;
      frames_left_d = frames_left_q;
      over_cnt_d    = over_cnt_q;
`ifdef GAME_STATE_XSIT_TIMEOUT_EN
      xsit_cnt_d    = xsit_cnt_q;
      if (state_q == ST_TRANSITION && FrameTick) begin
         xsit_cnt_d = xsit_cnt_q + 16'd1;
      end
`endif
      case (state_q)
         ST_TITLE: begin
            if (press.one) begin
               two_player_d = 1'b0;
            end else if (press.two) begin
               two_player_d = 1'b1;
            end
            if (press.enter) begin
               state_d       = ST_TRANSITION;
               frames_left_d = ROUND_LEN;
`ifdef GAME_STATE_XSIT_TIMEOUT_EN
               xsit_cnt_d    = 16'd0;
`endif
            end
         end
         ST_TRANSITION: begin
            if (press.esc) begin
               state_d       = ST_TITLE;
               frames_left_d = ROUND_LEN;
            end else if (TransitionDone) begin
               state_d = ST_PLAY;
`ifdef GAME_STATE_XSIT_TIMEOUT_EN
            end else if (xsit_expire) begin
               state_d = ST_PLAY;
`endif
            end
         end
         ST_PLAY: begin
            // ESC beats P beats expiry; a pause swallows that cycle's tick.
            if (press.esc) begin
               state_d       = ST_TITLE;
               frames_left_d = ROUND_LEN;
            end else if (press.p) begin
               state_d = ST_PAUSE;
            end else if (FrameTick) begin
               if (frames_left_q == 16'd1) begin
                  frames_left_d = 16'd0;
                  state_d       = ST_OVER;
                  over_cnt_d    = 16'd0;
               end else if (frames_left_q != 16'd0) begin
                  frames_left_d = frames_left_q - 16'd1;
               end
            end
         end
         ST_PAUSE: begin
            if (press.esc) begin
               state_d       = ST_TITLE;
               frames_left_d = ROUND_LEN;
            end else if (press.p) begin
               state_d = ST_PLAY;
            end
         end
         ST_OVER: begin
            if (press.enter || (FrameTick && over_cnt_q == OVER_LAST)) begin
               state_d       = ST_TITLE;
               frames_left_d = ROUND_LEN;
            end else if (FrameTick) begin
               over_cnt_d = over_cnt_q + 16'd1;
            end
         end
         default: begin
            state_d       = ST_TITLE;
            frames_left_d = ROUND_LEN;
         end
      endcase
   end

   // Outputs are decoded from the next state so they move with state_q.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q       <= ST_TITLE;
         two_player_q  <= 1'b0;
         frames_left_q <= ROUND_LEN;
         over_cnt_q    <= 16'd0;
         start_game_q  <= 1'b0;
         start_xsit_q  <= 1'b0;
         game_active_q <= 1'b0;
         game_over_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         two_player_q  <= two_player_d;
         frames_left_q <= frames_left_d;
         over_cnt_q    <= over_cnt_d;
         start_game_q  <= (state_d != ST_TITLE);
         start_xsit_q  <= (state_d == ST_TRANSITION);
         game_active_q <= (state_d == ST_PLAY);
         game_over_q   <= (state_d == ST_OVER);
      end
   end

   assign StartGame       = start_game_q;
   assign StartTransition = start_xsit_q;
   assign GameActive      = game_active_q;
   assign GameOver        = game_over_q;
   assign TwoPlayer       = two_player_q;
   assign FramesLeft      = frames_left_q;
   assign DbgState        = state_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Bench for game_state_ctrl: a vector table for the title/transition/play
// flow, then hand-written sequences for round expiry, game over and reset.
module tb_game_state_ctrl;
   import game_pkg::*;

   localparam int W = 24;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        frame_tick = 1'b0;
   logic [7:0]  keycode = 8'h00;
   logic        tdone = 1'b0;
   logic        start_game, start_xsit, game_active, game_over, two_player;
   logic [15:0] frames_left;
   logic [2:0]  dbg_state;

   logic [W-1:0] exp_q[$];
   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic        rst;
      logic        tick;
      logic [7:0]  key;
      logic        tdone;
      game_state_e st;
      logic        two;
      logic [15:0] frames;
   } vec_t;

   vec_t tbl[23];

   always #5 clk = ~clk;

   game_state_ctrl #(.ROUND_FRAMES(3600), .OVER_FRAMES(300)) dut (
      .Clk             (clk),
      .Reset           (rst),
      .FrameTick       (frame_tick),
      .keycode         (keycode),
      .TransitionDone  (tdone),
      .StartGame       (start_game),
      .StartTransition (start_xsit),
      .GameActive      (game_active),
      .GameOver        (game_over),
      .TwoPlayer       (two_player),
      .FramesLeft      (frames_left),
      .DbgState        (dbg_state)
   );

   function automatic logic [W-1:0] make_exp(game_state_e st, logic two, logic [15:0] fr);
      return {3'(st), st != ST_TITLE, st == ST_TRANSITION, st == ST_PLAY, st == ST_OVER, two, fr};
   endfunction

   // Drive one cycle of inputs, push the expectation, compare after the edge.
   task automatic step(input logic r, input logic tick, input logic [7:0] key, input logic td,
                       input game_state_e st, input logic two, input logic [15:0] fr,
                       input string name);
      logic [W-1:0] got, exp;
      rst        = r;
      frame_tick = tick;
      keycode    = key;
      tdone      = td;
      exp_q.push_back(make_exp(st, two, fr));
      @(posedge clk);
      #1;
      got = {dbg_state, start_game, start_xsit, game_active, game_over, two_player, frames_left};
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got state=%0d sg=%b st=%b ga=%b go=%b two=%b frames=%0d, expected state=%0d sg=%b st=%b ga=%b go=%b two=%b frames=%0d",
                  name, got[23:21], got[20], got[19], got[18], got[17], got[16], got[15:0],
                  exp[23:21], exp[20], exp[19], exp[18], exp[17], exp[16], exp[15:0]);
      end
   endtask

   task automatic tick_n(input int n);
      for (int i = 0; i < n; i++) begin
         rst        = 1'b0;
         frame_tick = 1'b1;
         keycode    = 8'h00;
         tdone      = 1'b0;
         @(posedge clk);
         #1;
      end
      frame_tick = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      tbl[0]  = '{1'b0, 1'b0, 8'h1F, 1'b0, ST_TITLE,      1'b1, 16'd3600};
      tbl[1]  = '{1'b0, 1'b0, 8'h1F, 1'b0, ST_TITLE,      1'b1, 16'd3600};
      tbl[2]  = '{1'b0, 1'b0, 8'h1F, 1'b0, ST_TITLE,      1'b1, 16'd3600};
      tbl[3]  = '{1'b0, 1'b0, 8'h00, 1'b0, ST_TITLE,      1'b1, 16'd3600};
      tbl[4]  = '{1'b0, 1'b0, 8'h1E, 1'b0, ST_TITLE,      1'b0, 16'd3600};
      tbl[5]  = '{1'b0, 1'b0, 8'h1E, 1'b0, ST_TITLE,      1'b0, 16'd3600};
      tbl[6]  = '{1'b0, 1'b0, 8'h1F, 1'b0, ST_TITLE,      1'b1, 16'd3600};
      tbl[7]  = '{1'b0, 1'b0, 8'h28, 1'b1, ST_TRANSITION, 1'b1, 16'd3600};
      tbl[8]  = '{1'b0, 1'b0, 8'h28, 1'b0, ST_TRANSITION, 1'b1, 16'd3600};
      tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, ST_PLAY,       1'b1, 16'd3600};
      tbl[10] = '{1'b0, 1'b1, 8'h00, 1'b0, ST_PLAY,       1'b1, 16'd3599};
      tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b0, ST_PLAY,       1'b1, 16'd3599};
      tbl[12] = '{1'b0, 1'b1, 8'h13, 1'b0, ST_PAUSE,      1'b1, 16'd3599};
      tbl[13] = '{1'b0, 1'b1, 8'h13, 1'b0, ST_PAUSE,      1'b1, 16'd3599};
      tbl[14] = '{1'b0, 1'b1, 8'h00, 1'b0, ST_PAUSE,      1'b1, 16'd3599};
      tbl[15] = '{1'b0, 1'b0, 8'h13, 1'b0, ST_PLAY,       1'b1, 16'd3599};
      tbl[16] = '{1'b0, 1'b1, 8'h13, 1'b0, ST_PLAY,       1'b1, 16'd3598};
      tbl[17] = '{1'b0, 1'b0, 8'h29, 1'b0, ST_TITLE,      1'b1, 16'd3600};
      tbl[18] = '{1'b0, 1'b0, 8'h29, 1'b0, ST_TITLE,      1'b1, 16'd3600};
      tbl[19] = '{1'b0, 1'b0, 8'h28, 1'b0, ST_TRANSITION, 1'b1, 16'd3600};
      tbl[20] = '{1'b0, 1'b0, 8'h29, 1'b1, ST_TITLE,      1'b1, 16'd3600};
      tbl[21] = '{1'b0, 1'b0, 8'h28, 1'b0, ST_TRANSITION, 1'b1, 16'd3600};
      tbl[22] = '{1'b0, 1'b0, 8'h00, 1'b1, ST_PLAY,       1'b1, 16'd3600};

      // Reset state
      @(posedge clk);
      #1;
      step(1'b1, 1'b0, 8'h00, 1'b0, ST_TITLE, 1'b0, 16'd3600, "reset");

      foreach (tbl[i]) begin
         step(tbl[i].rst, tbl[i].tick, tbl[i].key, tbl[i].tdone,
              tbl[i].st, tbl[i].two, tbl[i].frames, $sformatf("vec%0d", i));
      end

      for (int i = 1; i <= 10; i++) begin
         step(1'b0, 1'b1, 8'h00, 1'b0, ST_PLAY, 1'b1, 16'(3600 - i), "countdown");
      end

      // Final tick coinciding with P: pause wins and the last frame is kept
      tick_n(3589);
      step(1'b0, 1'b1, 8'h13, 1'b0, ST_PAUSE, 1'b1, 16'd1, "p_on_last_tick");
      step(1'b0, 1'b0, 8'h00, 1'b0, ST_PAUSE, 1'b1, 16'd1, "pause_hold");
      step(1'b0, 1'b1, 8'h00, 1'b0, ST_PAUSE, 1'b1, 16'd1, "pause_frozen");
      step(1'b0, 1'b0, 8'h13, 1'b0, ST_PLAY,  1'b1, 16'd1, "resume");
      step(1'b0, 1'b0, 8'h00, 1'b0, ST_PLAY,  1'b1, 16'd1, "resume_idle");
      step(1'b0, 1'b1, 8'h00, 1'b0, ST_OVER,  1'b1, 16'd0, "expire");
      step(1'b0, 1'b1, 8'h00, 1'b0, ST_OVER,  1'b1, 16'd0, "over_no_wrap");
      tick_n(297);
      step(1'b0, 1'b1, 8'h00, 1'b0, ST_OVER,  1'b1, 16'd0, "over_tick299");
      step(1'b0, 1'b1, 8'h00, 1'b0, ST_TITLE, 1'b1, 16'd3600, "over_timeout");

      // Second round, leaving OVER with ENTER
      step(1'b0, 1'b0, 8'h28, 1'b0, ST_TRANSITION, 1'b1, 16'd3600, "round2_enter");
      step(1'b0, 1'b0, 8'h00, 1'b1, ST_PLAY,       1'b1, 16'd3600, "round2_play");
      tick_n(3599);
      step(1'b0, 1'b1, 8'h00, 1'b0, ST_OVER,  1'b1, 16'd0, "round2_expire");
      step(1'b0, 1'b1, 8'h00, 1'b0, ST_OVER,  1'b1, 16'd0, "round2_over");
      step(1'b0, 1'b0, 8'h28, 1'b0, ST_TITLE, 1'b1, 16'd3600, "over_enter");

      // ESC from PAUSE
      step(1'b0, 1'b0, 8'h00, 1'b0, ST_TITLE,      1'b1, 16'd3600, "idle");
      step(1'b0, 1'b0, 8'h28, 1'b0, ST_TRANSITION, 1'b1, 16'd3600, "enter3");
      step(1'b0, 1'b0, 8'h00, 1'b1, ST_PLAY,       1'b1, 16'd3600, "play3");
      step(1'b0, 1'b0, 8'h13, 1'b0, ST_PAUSE,      1'b1, 16'd3600, "pause3");
      step(1'b0, 1'b0, 8'h29, 1'b0, ST_TITLE,      1'b1, 16'd3600, "pause_esc");

      // Reset in PAUSE with P held
      step(1'b0, 1'b0, 8'h28, 1'b0, ST_TRANSITION, 1'b1, 16'd3600, "enter4");
      step(1'b0, 1'b0, 8'h00, 1'b1, ST_PLAY,       1'b1, 16'd3600, "play4");
      step(1'b0, 1'b1, 8'h00, 1'b0, ST_PLAY,       1'b1, 16'd3599, "play4_tick");
      step(1'b0, 1'b0, 8'h13, 1'b0, ST_PAUSE,      1'b1, 16'd3599, "pause4");
      step(1'b1, 1'b1, 8'h13, 1'b0, ST_TITLE,      1'b0, 16'd3600, "reset_in_pause");
      step(1'b0, 1'b0, 8'h13, 1'b0, ST_TITLE,      1'b0, 16'd3600, "after_reset_held");
      step(1'b0, 1'b0, 8'h00, 1'b0, ST_TITLE,      1'b0, 16'd3600, "after_reset_rel");
      step(1'b0, 1'b0, 8'h13, 1'b0, ST_TITLE,      1'b0, 16'd3600, "p_in_title");

      // TRANSITION without TransitionDone
      step(1'b0, 1'b0, 8'h28, 1'b0, ST_TRANSITION, 1'b0, 16'd3600, "enter5");
`ifdef GAME_STATE_XSIT_TIMEOUT_EN
      tick_n(238);
      step(1'b0, 1'b1, 8'h00, 1'b0, ST_TRANSITION, 1'b0, 16'd3600, "xsit_tick239");
      step(1'b0, 1'b1, 8'h00, 1'b0, ST_PLAY,       1'b0, 16'd3600, "xsit_timeout");
`else
      tick_n(240);
      step(1'b0, 1'b1, 8'h00, 1'b0, ST_TRANSITION, 1'b0, 16'd3600, "xsit_waits");
      step(1'b0, 1'b0, 8'h29, 1'b0, ST_TITLE,      1'b0, 16'd3600, "xsit_esc");
`endif

      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
